// File: rtl/led_pattern_engine.sv
// LED pattern engine: decodes the 7-bit LED PIO command into direct, blink,
// bounce-scan or PWM-breathe patterns, with all timing generated locally.
module led_pattern_engine #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned LED_W    = 8
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [6:0]       led_cmd,
    output logic [LED_W-1:0] leds_out,
    output logic [1:0]       mode_status,
    output logic             step_pulse
);

    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW   = 7;
    localparam int unsigned RW   = 5;
    localparam int unsigned DW   = 8;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [LED_W-1:0] PAT_FIRST  = LED_W'(1);
    localparam logic [LED_W-1:0] PAT_LAST   = PAT_FIRST << (LED_W - 1);
    localparam logic [DW-1:0]    DUTY_MAX   = '1;

    localparam logic [1:0] MODE_DIRECT  = 2'b00;
    localparam logic [1:0] MODE_BLINK   = 2'b01;
    localparam logic [1:0] MODE_SCAN    = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    logic [CW-1:0]    cmd_q,      cmd_n;
    logic [PW-1:0]    presc,      presc_n;
    logic [RW-1:0]    step_cnt,   step_cnt_n;
    logic [DW-1:0]    pwm_cnt,    pwm_cnt_n;
    logic [LED_W-1:0] pat,        pat_n;
    logic             scan_right, scan_right_n;
    logic [DW-1:0]    duty,       duty_n;
    logic             duty_down,  duty_down_n;
    logic             step_d,     step_d_n;
    logic [LED_W-1:0] leds_n;
    logic             step_pulse_n;

    logic change_c;
    logic tick_c;
    logic step_c;

    // Mode/pattern state register; cmd_q[6:5] is the FSM state.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cmd_q      <= '0;
            presc      <= '0;
            step_cnt   <= '0;
            pwm_cnt    <= '0;
            pat        <= '0;
            scan_right <= 1'b0;
            duty       <= '0;
            duty_down  <= 1'b0;
            step_d     <= 1'b0;
            leds_out   <= '0;
            step_pulse <= 1'b0;
        end else begin
            cmd_q      <= cmd_n;
            presc      <= presc_n;
            step_cnt   <= step_cnt_n;
            pwm_cnt    <= pwm_cnt_n;
            pat        <= pat_n;
            scan_right <= scan_right_n;
            duty       <= duty_n;
            duty_down  <= duty_down_n;
            step_d     <= step_d_n;
            leds_out   <= leds_n;
            step_pulse <= step_pulse_n;
        end
    end

    assign mode_status = cmd_q[6:5];

    // Next-state: a command change reloads everything and overrides a coincident step.
    always_comb begin
        cmd_n        = led_cmd;
        presc_n      = presc;
        step_cnt_n   = step_cnt;
        pwm_cnt_n    = pwm_cnt + DW'(1);
        pat_n        = pat;
        scan_right_n = scan_right;
        duty_n       = duty;
        duty_down_n  = duty_down;
        step_d_n     = 1'b0;
        leds_n       = '0;
        step_pulse_n = step_d;

        change_c = (led_cmd != cmd_q);
        tick_c   = (presc == PRESC_LAST);
        step_c   = tick_c && (step_cnt == cmd_q[4:0]);

        presc_n = tick_c ? '0 : presc + PW'(1);
        if (tick_c) begin
            step_cnt_n = step_c ? '0 : step_cnt + RW'(1);
        end

        if (change_c) begin
            presc_n      = '0;
            step_cnt_n   = '0;
            pwm_cnt_n    = '0;
            scan_right_n = 1'b0;
            duty_n       = '0;
            duty_down_n  = 1'b0;
            case (led_cmd[6:5])
                MODE_BLINK: pat_n = '1;
                MODE_SCAN:  pat_n = PAT_FIRST;
                default:    pat_n = '0;
            endcase
        end else if (step_c) begin
            case (cmd_q[6:5])
                MODE_BLINK: begin
                    pat_n    = ~pat;
                    step_d_n = 1'b1;
                end
                MODE_SCAN: begin
                    step_d_n = 1'b1;
                    if (!scan_right) begin
                        if (pat == PAT_LAST) begin
                            pat_n        = PAT_LAST >> 1;
                            scan_right_n = 1'b1;
                        end else begin
                            pat_n = pat << 1;
                        end
                    end else begin
                        if (pat == PAT_FIRST) begin
                            pat_n        = PAT_FIRST << 1;
                            scan_right_n = 1'b0;
                        end else begin
                            pat_n = pat >> 1;
                        end
                    end
                end
                MODE_BREATHE: begin
                    step_d_n = 1'b1;
                    // Turn around at the rails so duty never wraps.
                    if (!duty_down) begin
                        if (duty == DUTY_MAX) begin
                            duty_n      = DUTY_MAX - DW'(1);
                            duty_down_n = 1'b1;
                        end else begin
                            duty_n = duty + DW'(1);
                        end
                    end else begin
                        if (duty == '0) begin
                            duty_n      = DW'(1);
                            duty_down_n = 1'b0;
                        end else begin
                            duty_n = duty - DW'(1);
                        end
                    end
                end
                default: begin
                    step_d_n = 1'b0;
                end
            endcase
        end

        case (cmd_q[6:5])
            MODE_DIRECT:  leds_n = LED_W'(cmd_q[4:0]);
            MODE_BLINK:   leds_n = pat;
            MODE_SCAN:    leds_n = pat;
            MODE_BREATHE: leds_n = {LED_W{pwm_cnt < duty}};
            default:      leds_n = '0;
        endcase
    end

endmodule
